pattern_stream_source: RTL and testbench
========================================

Name: pattern_stream_source

Overview:
- Transmit-side companion of the "boab" byte-stream pattern detector. Generates 8-bit data: filler gap, then "b","o","a","b" (0x62 0x6F 0x61 0x62), then a non-'b' terminator.
- Drives the ack line per the detector protocol and samples found_pattern. Counts passes and timeouts per frame.
- Used as on-chip stimulus and self-check for the detector. Outputs connect directly to the detector's data/ack inputs.

Parameters:
- TIMEOUT, 8, cycles to wait for found_pattern after the final 'b' before declaring a fail (>=2).
- IDLE_BYTE, 8'h00, data value driven when not busy.
- SUB_BYTE, 8'h2E, replacement when the requested filler equals 'b' (0x62).

Ports:
- clk  in  1  rising-edge clock
- reset_sync_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; ignored while busy
- reps  in  8  frames to send, sampled on start
- gap_len  in  8  filler bytes before each pattern, sampled on start
- filler  in  8  filler byte, sampled on start
- ack_mode  in  1  ack level on the final 'b': 0 = low-path, 1 = high-path; sampled on start
- found_pattern  in  1  detector result
- data  out  8  byte stream to the detector
- ack  out  1  handshake to the detector
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at the end of a run
- pass_cnt  out  8  frames with found_pattern seen; saturates at 255
- fail_cnt  out  8  frames that timed out; saturates at 255

Behaviour:
- All outputs are registered. Reset values: data=IDLE_BYTE, ack=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, FSM=IDLE, all counters 0.
- Reset has priority over every other event. Asserting reset mid-frame returns to IDLE on that edge with all reset values; no done pulse.
- start accepted in IDLE only:
  - Latches reps, gap_len, filler_q, ack_mode_q; clears pass_cnt and fail_cnt.
  - filler_q = SUB_BYTE if filler==0x62, else filler.
  - If reps==0: no frame; done pulses the next cycle and busy stays 0.
- One state per cycle except GAP, WAIT and ACK. The values listed are data/ack for the cycle spent in that state.
  - IDLE: data=IDLE_BYTE, ack=0. On an accepted start with reps>0, go to GAP if gap_len>0, else B0.
  - GAP: data=filler_q, ack=0, for exactly gap_len cycles, then B0.
  - B0: data=0x62, ack=0. ack must be low here, because the detector only starts on 'b' with ack=0. Next: O.
  - O: data=0x6F, ack=0. Next: A.
  - A: data=0x61, ack=0. Next: B1.
  - B1: data=0x62, ack=ack_mode_q. Next: WAIT.
  - WAIT: data=filler_q (the non-'b' terminator), ack=ack_mode_q held stable.
    - Wait timer starts at 0 on entry.
    - If found_pattern==1: pass_cnt+1 (saturating), go to ACK.
    - Else if timer==TIMEOUT-1: fail_cnt+1 (saturating), go to ACK.
    - found_pattern takes priority when both happen in the same cycle.
  - ACK: data=filler_q, ack=~ack_mode_q for one cycle, which returns the detector to its initial state. Then decrement the remaining frame count:
    - remaining>0: go to GAP (or B0 if gap_len==0).
    - remaining==0: go to IDLE and pulse done with the IDLE entry; busy falls in the same cycle.
- found_pattern outside WAIT is ignored and does not change the counters.
- Frame length with detection at wait cycle k (0-based): gap_len + 4 + (k+1) + 1 cycles.
- Back-to-back frames have no IDLE cycle between them.

Decomposition:
- Package pattern_pkg holds:
  - the character constants CH_B=8'h62, CH_O=8'h6F, CH_A=8'h61
  - the FSM state enum (IDLE, GAP, B0, O, A, B1, WAIT, ACK), typedef src_state_t, 4-bit encoding.
- The detector should also import the character constants from pattern_pkg.
- No sub-module is needed; the saturating 8-bit counter is written inline twice.

Test Plan:
- reps=1, gap_len=2, filler=0x41, ack_mode=0, found_pattern tied to the real detector:
  - data sequence 41 41 62 6F 61 62 41…
  - ack stays 0 until the one-cycle ACK high.
  - After the run: pass_cnt=1, fail_cnt=0, one done pulse.
- Same as the previous case with ack_mode=1:
  - ack=1 on B1 and through WAIT, then 0 for the ACK cycle.
  - pass_cnt=1.
- found_pattern tied to 0, reps=3, TIMEOUT=8: each WAIT lasts exactly 8 cycles; fail_cnt=3, pass_cnt=0; done once.
- filler=0x62: every gap and terminator byte is 0x2E; the detector passes; pass_cnt=1.
- reps=0 start -> done the next cycle, busy never high, no 0x62 on data. A start pulse while busy has no effect on counters or sequence.
- reset_sync_n=0 during O of frame 2 of reps=4 -> next cycle data=0x00, ack=0, busy=0, counters=0, no done. A new start then runs normally.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared character constants and source FSM encoding for the "boab" pattern pair.
package pattern_pkg;

  localparam logic [7:0] CH_B = 8'h62;
  localparam logic [7:0] CH_O = 8'h6F;
  localparam logic [7:0] CH_A = 8'h61;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    GAP  = 4'd1,
    B0   = 4'd2,
    O    = 4'd3,
    A    = 4'd4,
    B1   = 4'd5,
    WAIT = 4'd6,
    ACK  = 4'd7
  } src_state_t;

endpackage

// File: rtl/pattern_stream_source.sv
// Frame generator for the "boab" detector: filler gap, pattern, terminator,
// then waits for found_pattern and tallies passes and timeouts.
module pattern_stream_source
  import pattern_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 8,
  parameter logic [7:0]  IDLE_BYTE = 8'h00,
  parameter logic [7:0]  SUB_BYTE  = 8'h2E
) (
  input  logic       clk,
  input  logic       reset_sync_n,
  input  logic       start,
  input  logic [7:0] reps,
  input  logic [7:0] gap_len,
  input  logic [7:0] filler,
  input  logic       ack_mode,
  input  logic       found_pattern,
  output logic [7:0] data,
  output logic       ack,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt
);

  localparam int unsigned TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  src_state_t state, state_nxt;

  logic [7:0]         frames_left;
  logic [7:0]         gap_len_q;
  logic [7:0]         gap_cnt;
  logic [7:0]         filler_q;
  logic               ack_mode_q;
  logic [TIMER_W-1:0] timer;

  logic [7:0] data_d;
  logic       ack_d;
  logic       busy_d;
  logic       done_d;

  logic       accept;
  logic [7:0] filler_sub;
  logic [7:0] fill_eff;
  logic       am_eff;
  logic       gap_nonzero;
  logic       last_gap;
  logic       timeout_hit;

  // In IDLE the latched copies are not yet valid, so the first frame uses the live inputs.
  assign accept      = (state == IDLE) && start;
  assign filler_sub  = (filler == CH_B) ? SUB_BYTE : filler;
  assign fill_eff    = (state == IDLE) ? filler_sub : filler_q;
  assign am_eff      = (state == IDLE) ? ack_mode : ack_mode_q;
  assign gap_nonzero = (state == IDLE) ? (gap_len != 8'd0) : (gap_len_q != 8'd0);
  assign last_gap    = (gap_cnt == (gap_len_q - 8'd1));
  assign timeout_hit = (timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (!reset_sync_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && (reps != 8'd0)) state_nxt = gap_nonzero ? GAP : B0;
      GAP:  if (last_gap) state_nxt = B0;
      B0:   state_nxt = O;
      O:    state_nxt = A;
      A:    state_nxt = B1;
      B1:   state_nxt = WAIT;
      WAIT: if (found_pattern || timeout_hit) state_nxt = ACK;
      ACK:  begin
        if (frames_left == 8'd1) state_nxt = IDLE;
        else                     state_nxt = gap_nonzero ? GAP : B0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output values are decoded from the upcoming state and registered below.
  always_comb begin
    data_d = IDLE_BYTE;
    ack_d  = 1'b0;
    busy_d = (state_nxt != IDLE);
    done_d = (accept && (reps == 8'd0)) || ((state == ACK) && (state_nxt == IDLE));
    unique case (state_nxt)
      GAP:  data_d = fill_eff;
      B0:   data_d = CH_B;
      O:    data_d = CH_O;
      A:    data_d = CH_A;
      B1:   begin data_d = CH_B;     ack_d = am_eff;  end
      WAIT: begin data_d = fill_eff; ack_d = am_eff;  end
      ACK:  begin data_d = fill_eff; ack_d = ~am_eff; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_sync_n) begin
      data        <= IDLE_BYTE;
      ack         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass_cnt    <= 8'd0;
      fail_cnt    <= 8'd0;
      frames_left <= 8'd0;
      gap_len_q   <= 8'd0;
      gap_cnt     <= 8'd0;
      filler_q    <= 8'd0;
      ack_mode_q  <= 1'b0;
      timer       <= '0;
    end else begin
      data <= data_d;
      ack  <= ack_d;
      busy <= busy_d;
      done <= done_d;

      if (accept) begin
        frames_left <= reps;
        gap_len_q   <= gap_len;
        filler_q    <= filler_sub;
        ack_mode_q  <= ack_mode;
        pass_cnt    <= 8'd0;
        fail_cnt    <= 8'd0;
      end

      if ((state_nxt == GAP) && (state != GAP)) gap_cnt <= 8'd0;
      else if (state == GAP)                    gap_cnt <= gap_cnt + 8'd1;

      if (state == WAIT) timer <= timer + TIMER_W'(1);
      else               timer <= '0;

      if (state == WAIT) begin
        if (found_pattern) begin
          if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
        end else if (timeout_hit) begin
          if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
        end
      end

      if (state == ACK) frames_left <= frames_left - 8'd1;
    end
  end

endmodule

// File: tb/tb_pattern_stream_source.sv
// Randomized bench for pattern_stream_source against a per-cycle frame timeline model.
module tb_pattern_stream_source;

  localparam int unsigned TO = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       a;
    logic       b;
    logic       dn;
    logic [7:0] pc;
    logic [7:0] fc;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset_sync_n;
  logic       start;
  logic [7:0] reps, gap_len, filler;
  logic       ack_mode;
  logic       found_pattern;
  logic [7:0] data;
  logic       ack, busy, done;
  logic [7:0] pass_cnt, fail_cnt;

  int passed = 0;
  int total  = 0;

  ent_t exp_q[$];
  logic exp_f[$];
  ent_t obs_q[$];

  pattern_stream_source #(.TIMEOUT(TO), .IDLE_BYTE(8'h00), .SUB_BYTE(8'h2E)) dut (
    .clk(clk), .reset_sync_n(reset_sync_n), .start(start), .reps(reps),
    .gap_len(gap_len), .filler(filler), .ack_mode(ack_mode),
    .found_pattern(found_pattern), .data(data), .ack(ack), .busy(busy),
    .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Expected timeline, one entry per cycle starting with the cycle after the accepting edge.
  // kmode: 0 = detect at random wait cycle, 1 = never detect, 2 = mixed.
  task automatic model_run(input int r, input int g, input logic [7:0] fl,
                           input logic am, input int kmode, input bit noise);
    logic [7:0] fe;
    int pc, fc, k, n;
    fe = (fl == 8'h62) ? 8'h2E : fl;
    pc = 0; fc = 0;
    exp_q.delete(); exp_f.delete();
    for (int f = 0; f < r; f++) begin
      for (int i = 0; i < g; i++) begin
        exp_q.push_back({fe, 1'b0, 1'b1, 1'b0, 8'(pc), 8'(fc)});
        exp_f.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      exp_q.push_back({8'h62, 1'b0, 1'b1, 1'b0, 8'(pc), 8'(fc)});
      exp_q.push_back({8'h6F, 1'b0, 1'b1, 1'b0, 8'(pc), 8'(fc)});
      exp_q.push_back({8'h61, 1'b0, 1'b1, 1'b0, 8'(pc), 8'(fc)});
      exp_q.push_back({8'h62, am,   1'b1, 1'b0, 8'(pc), 8'(fc)});
      for (int i = 0; i < 4; i++) exp_f.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
      if (kmode == 1 || (kmode == 2 && $urandom_range(0, 3) == 0)) k = -1;
      else k = int'($urandom_range(0, TO - 1));
      n = (k < 0) ? TO : k + 1;
      for (int w = 0; w < n; w++) begin
        exp_q.push_back({fe, am, 1'b1, 1'b0, 8'(pc), 8'(fc)});
        exp_f.push_back(w == k);
      end
      if (k >= 0) pc = (pc < 255) ? pc + 1 : 255;
      else        fc = (fc < 255) ? fc + 1 : 255;
      exp_q.push_back({fe, ~am, 1'b1, 1'b0, 8'(pc), 8'(fc)});
      exp_f.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    exp_q.push_back({8'h00, 1'b0, 1'b0, 1'b1, 8'(pc), 8'(fc)});
    exp_q.push_back({8'h00, 1'b0, 1'b0, 1'b0, 8'(pc), 8'(fc)});
    exp_f.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
    exp_f.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  task automatic kick(input int r, input int g, input logic [7:0] fl, input logic am);
    @(negedge clk);
    reps = 8'(r); gap_len = 8'(g); filler = fl; ack_mode = am;
    start = 1'b1; found_pattern = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drives found_pattern from the timeline and records outputs each cycle.
  task automatic play(input int busy_start_at, input int reset_at);
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      found_pattern = exp_f[i];
      start = (i == busy_start_at);
      if (i == busy_start_at) begin
        reps = 8'($urandom_range(0, 255)); gap_len = 8'($urandom_range(0, 255));
        filler = 8'($urandom); ack_mode = 1'($urandom);
      end
      reset_sync_n = (i != reset_at);
      obs_q.push_back({data, ack, busy, done, pass_cnt, fail_cnt});
      @(posedge clk);
      #1;
    end
    start = 1'b0; found_pattern = 1'b0; reset_sync_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_sync_n = 1'b0; start = 1'b0; found_pattern = 1'b0;
    reps = 8'd0; gap_len = 8'd0; filler = 8'd0; ack_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_sync_n = 1'b1;
    total++; if (data !== 8'h00) $display("FAIL reset_data got %h exp 00", data); else passed++;
    total++; if (ack !== 1'b0) $display("FAIL reset_ack got %b exp 0", ack); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
    total++; if (pass_cnt !== 8'd0) $display("FAIL reset_pass got %0d exp 0", pass_cnt); else passed++;
    total++; if (fail_cnt !== 8'd0) $display("FAIL reset_fail got %0d exp 0", fail_cnt); else passed++;
  endtask

  task automatic test_basic(input logic am);
    model_run(1, 2, 8'h41, am, 0, 1'b0);
    kick(1, 2, 8'h41, am);
    play(-1, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL basic_am%0b cyc=%0d got %h exp %h", am, i, obs_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    model_run(3, 1, 8'h55, 1'b0, 1, 1'b0);
    kick(3, 1, 8'h55, 1'b0);
    play(-1, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL timeout cyc=%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    total++;
    if (fail_cnt !== 8'd3) $display("FAIL timeout_total got %0d exp 3", fail_cnt); else passed++;
  endtask

  task automatic test_filler_b();
    model_run(1, 3, 8'h62, 1'b1, 0, 1'b0);
    kick(1, 3, 8'h62, 1'b1);
    play(-1, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL filler_b cyc=%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_reps_zero();
    model_run(0, 4, 8'h41, 1'b0, 0, 1'b1);
    kick(0, 4, 8'h41, 1'b0);
    play(-1, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL reps_zero cyc=%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_start_while_busy();
    model_run(2, 1, 8'h33, 1'b0, 2, 1'b1);
    kick(2, 1, 8'h33, 1'b0);
    play(3, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL busy_start cyc=%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int g, idx, seen;
    g = int'($urandom_range(0, 3));
    model_run(4, g, 8'h20, 1'b0, 0, 1'b0);
    idx = -1; seen = 0;
    for (int i = 0; i < exp_q.size() && idx < 0; i++)
      if (exp_q[i].d == 8'h6F) begin
        seen++;
        if (seen == 2) idx = i;
      end
    while (exp_q.size() > idx + 1) begin
      void'(exp_q.pop_back());
      void'(exp_f.pop_back());
    end
    repeat (3) begin
      exp_q.push_back({8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
      exp_f.push_back(1'b0);
    end
    kick(4, g, 8'h20, 1'b0);
    play(-1, idx);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL reset_mid cyc=%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    int r, g;
    logic [7:0] fl;
    logic am;
    for (int run = 0; run < 6; run++) begin
      r  = int'($urandom_range(1, 4));
      g  = int'($urandom_range(0, 5));
      fl = ($urandom_range(0, 3) == 0) ? 8'h62 : 8'($urandom);
      am = 1'($urandom);
      model_run(r, g, fl, am, 2, 1'b1);
      kick(r, g, fl, am);
      play(-1, -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i])
          $display("FAIL random%0d cyc=%0d got %h exp %h", run, i, obs_q[i], exp_q[i]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_timeout();
    test_filler_b();
    test_reps_zero();
    test_start_while_busy();
    test_reset_mid();
    test_basic(1'b0);
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
